icache_fetch: RTL
=================

// Module: icache_fetch
// PURPOSE
// - Direct-mapped, one-word-per-line instruction cache between the IF stage and the byte-serial memory controller.
// - Hits return an instruction one cycle after the PC is presented. Misses issue a word fetch to the memory
//   controller, stall IF, fill the line and forward the word.
// - Removes the four-cycle byte fetch from every instruction except cold or conflicting PCs.
// PARAMETERS
// - IDX_W   7   index bits; LINES = 2**IDX_W
// - ADDR_W  17  cached physical address bits; tag = pc[ADDR_W-1:IDX_W+2]
// PORTS
// - clk             in   1   clock
// - rst             in   1   reset: synchronous, active-high
// - rdy_in          in   1   global ready; 0 freezes all state and outputs
// - pc_i            in   32  fetch address; pc_i[1:0] ignored
// - pc_valid_i      in   1   pc_i holds a new request this cycle
// - stall_i         in   1   pipeline stall; hold output, accept no request
// - flush_i         in   1   branch redirect; discard the in-flight request
// - inv_i           in   1   invalidate all lines (fence.i)
// - inst_o          out  32  fetched instruction
// - inst_pc_o       out  32  PC of inst_o
// - inst_valid_o    out  1   inst_o/inst_pc_o valid
// - if_stall_req_o  out  1   miss in progress; IF must hold pc_i
// - mem_req_o       out  1   word fetch request to the memory controller
// - mem_addr_o      out  32  fetch address, bits [1:0] = 0
// - mem_done_i      in   1   one-cycle pulse: mem_inst_i valid
// - mem_inst_i      in   32  fetched word
// BEHAVIOUR
// - Reset: all valid bits 0, state IDLE. Every output 0. Drop flag cleared.
// - rdy_in = 0: no state, array or output changes. A mem_done_i pulse in that cycle is ignored.
// - IDLE, pc_valid_i = 1 and stall_i = 0:
//   - Index = pc_i[IDX_W+1:2]. Hit = valid[idx] and tag match.
//   - Hit: next cycle inst_o = data[idx], inst_pc_o = pc_i, inst_valid_o = 1.
//   - Miss: latch the PC and go to MISS. The next cycle drives mem_req_o = 1, mem_addr_o = {pc[31:2],2'b00},
//     if_stall_req_o = 1, inst_valid_o = 0.
// - IDLE with no accepted request:
//   - inst_valid_o drops to 0 the next cycle.
//   - If stall_i = 1, inst_o, inst_pc_o and inst_valid_o hold their values instead.
// - MISS: mem_req_o and mem_addr_o stay stable until mem_done_i. On mem_done_i:
//   - Write data, tag and valid, unless the address is in the IO region (pc[17:16] == 2'b11); IO words are never cached.
//   - Drop mem_req_o and if_stall_req_o the next cycle.
//   - If the drop flag is clear: inst_o = mem_inst_i and inst_valid_o = 1 for one cycle.
//   - Return to IDLE.
// - Miss latency: 1 cycle after mem_done_i. Hit latency: 1 cycle.
// - flush_i:
//   - In IDLE: cancels this cycle's request and forces inst_valid_o = 0 the next cycle.
//   - In MISS: sets the drop flag. The fill still completes and writes the array, but inst_valid_o stays 0.
//   - Both cases clear stall hold.
// - flush_i and pc_valid_i in the same cycle: flush wins and no lookup is made. IF re-presents the target next cycle.
// - inv_i:
//   - Clears all valid bits in one cycle.
//   - With a simultaneous fill write, invalidate wins and the line is left invalid.
//   - The forwarded word is still delivered.
// - Tag and valid compare is combinational. Data, tag and valid are registered arrays with one write port
//   and one async read port.
// CONFIGURATION
// - ICACHE_PERF_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
//   - Each increments once per accepted lookup, wrapping at 2**32.
//   - Both reset to 0 and freeze while rdy_in = 0.
// - ICACHE_PERF_EN undefined: these ports and counters are absent. Behaviour is otherwise identical.
// STRUCTURE
// - Shared defines package: IDX_W/TAG_W defaults, state encoding (IDLE = 1'b0, MISS = 1'b1),
//   IO region constant 2'b11, ZeroWord.
// - One sub-module, icache_array: valid vector, tag and data storage, hit compare, invalidate-all and write port.
// - Top level holds the FSM, drop flag, output registers and the optional perf counters.
// TESTING
// - Cold fetch at 0x0000_0010: mem_req_o = 1, mem_addr_o = 0x10. Return 0x00A00093 after 4 cycles
//   -> inst_valid_o = 1, inst_o = 0x00A00093 one cycle after mem_done_i.
// - Re-fetch 0x10 -> hit; inst_o = 0x00A00093 next cycle; mem_req_o stays 0.
// - Conflict 0x210 (same index, IDX_W = 7) -> miss and refill. A later 0x10 misses again.
// - flush_i during the 0x40 miss: inst_valid_o stays 0 at mem_done_i. Re-fetch 0x40 -> hit, no mem_req_o.
// - Fetch 0x30000 (IO region) twice -> two memory requests. inv_i after a 0x10 fill -> the next 0x10 misses.
// - rdy_in = 0 for 3 cycles mid-miss, including a mem_done_i pulse -> state unchanged, pulse ignored,
//   request still held. stall_i on a hit -> inst_o held. Reset mid-miss -> all outputs 0, next fetch misses.

Source files
------------

// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// geometry defaults, FSM encoding and the uncached IO region.
package icache_fetch_pkg;

    localparam int IDX_W_DEF  = 7;
    localparam int ADDR_W_DEF = 17;
    localparam int TAG_W_DEF  = ADDR_W_DEF - IDX_W_DEF - 2;

    localparam logic [1:0]  IO_REGION = 2'b11;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    // Words from the IO window must always be fetched from memory.
    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_REGION;
    endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = cache side, master = IF stage plus memory controller side.
interface icache_fetch_if;

    logic        rdy_in;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        stall_i;
    logic        flush_i;
    logic        inv_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        if_stall_req_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_i;
    logic [31:0] mem_inst_i;

    modport slave (
        input  rdy_in, pc_i, pc_valid_i, stall_i, flush_i, inv_i, mem_done_i, mem_inst_i,
        output inst_o, inst_pc_o, inst_valid_o, if_stall_req_o, mem_req_o, mem_addr_o
    );

    modport master (
        output rdy_in, pc_i, pc_valid_i, stall_i, flush_i, inv_i, mem_done_i, mem_inst_i,
        input  inst_o, inst_pc_o, inst_valid_o, if_stall_req_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_fetch_array.sv
// Line storage for the cache: valid vector, tag and data arrays with one
// write port, one asynchronous read port, hit compare and invalidate-all.
module icache_array #(
    parameter int IDX_W = 7,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inv,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    input  logic [TAG_W-1:0] rtag,
    output logic             hit,
    output logic [31:0]      rdata
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    assign hit   = valid[ridx] && (tags[ridx] == rtag);
    assign rdata = data[ridx];

    // Invalidate has priority so a fill racing with fence.i leaves the line empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (en) begin
            if (inv) begin
                valid <= '0;
            end else if (we) begin
                valid[widx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            tags[widx] <= wtag;
            data[widx] <= wdata;
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped one-word-per-line instruction cache in front of the byte-serial memory controller.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_fetch_if.slave        bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    state_t      state;
    logic        drop;
    logic [31:0] miss_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic [31:0]      rdata;
    logic             accept;
    logic             fill_we;

    assign lookup_idx = bus.pc_i[IDX_W+1:2];
    assign lookup_tag = bus.pc_i[ADDR_W-1:IDX_W+2];
    assign fill_idx   = miss_pc[IDX_W+1:2];
    assign fill_tag   = miss_pc[ADDR_W-1:IDX_W+2];

    assign accept  = (state == IDLE) && bus.pc_valid_i && !bus.stall_i && !bus.flush_i;
    assign fill_we = (state == MISS) && bus.mem_done_i && !is_io(miss_pc);

    icache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.rdy_in),
        .inv   (bus.inv_i),
        .we    (fill_we),
        .widx  (fill_idx),
        .wtag  (fill_tag),
        .wdata (bus.mem_inst_i),
        .ridx  (lookup_idx),
        .rtag  (lookup_tag),
        .hit   (hit),
        .rdata (rdata)
    );

    // A flush during a miss only suppresses the forwarded word; the fill itself still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drop       <= 1'b0;
            miss_pc    <= ZeroWord;
            inst       <= ZeroWord;
            inst_pc    <= ZeroWord;
            inst_valid <= 1'b0;
            stall_req  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= ZeroWord;
        end else if (bus.rdy_in) begin
            case (state)
                IDLE: begin
                    if (bus.flush_i) begin
                        inst_valid <= 1'b0;
                    end else if (accept) begin
                        if (hit) begin
                            inst       <= rdata;
                            inst_pc    <= bus.pc_i;
                            inst_valid <= 1'b1;
                        end else begin
                            state      <= MISS;
                            miss_pc    <= bus.pc_i;
                            drop       <= 1'b0;
                            mem_req    <= 1'b1;
                            mem_addr   <= {bus.pc_i[31:2], 2'b00};
                            stall_req  <= 1'b1;
                            inst_valid <= 1'b0;
                        end
                    end else if (!bus.stall_i) begin
                        inst_valid <= 1'b0;
                    end
                end
                MISS: begin
                    if (bus.mem_done_i) begin
                        state     <= IDLE;
                        drop      <= 1'b0;
                        mem_req   <= 1'b0;
                        stall_req <= 1'b0;
                        if (drop || bus.flush_i) begin
                            inst_valid <= 1'b0;
                        end else begin
                            inst       <= bus.mem_inst_i;
                            inst_pc    <= miss_pc;
                            inst_valid <= 1'b1;
                        end
                    end else if (bus.flush_i) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.inst_o         = inst;
    assign bus.inst_pc_o      = inst_pc;
    assign bus.inst_valid_o   = inst_valid;
    assign bus.if_stall_req_o = stall_req;
    assign bus.mem_req_o      = mem_req;
    assign bus.mem_addr_o     = mem_addr;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= ZeroWord;
            miss_cnt_o <= ZeroWord;
        end else if (bus.rdy_in && accept) begin
            if (hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
